// File: rtl/bmf_pkg.sv
// Shared definitions for the Boolean-matrix-factorization decoder and the
// compressor-side evaluation models.
//   SEMIRING_OR / SEMIRING_XOR : selects the additive operator of the product
//   bmf_product(k, h, semiring) : y = k . H, computed at maximum widths and
//                                 truncated by the caller
package bmf_pkg;

  localparam int SEMIRING_OR  = 0;
  localparam int SEMIRING_XOR = 1;

  localparam int K_MAX = 8;
  localparam int M_MAX = 32;

  typedef logic [K_MAX-1:0]            kvec_t;
  typedef logic [K_MAX-1:0][M_MAX-1:0] hmat_t;
  typedef logic [M_MAX-1:0]            yvec_t;

  // Each set bit of k folds its H row into the accumulator, using either
  // OR or XOR as the sum operator.
  function automatic yvec_t bmf_product(input kvec_t k, input hmat_t h,
                                        input int semiring);
    yvec_t y;
    y = '0;
    for (int i = 0; i < K_MAX; i++) begin
      if (k[i]) begin
        if (semiring == SEMIRING_XOR) y = y ^ h[i];
        else                          y = y | h[i];
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/bmf_h_decoder_if.sv
// Bundle of the decoder's config, input-stream and output-stream signals.
//   master : latent-vector source / config writer / output consumer side
//   slave  : decoder side
interface bmf_h_decoder_if
  import bmf_pkg::*;
#(
  parameter int K = 3,
  parameter int M = 4
);
  localparam int RW = (K > 1) ? $clog2(K) : 1;

  logic          cfg_we;
  logic [RW-1:0] cfg_row;
  logic [M-1:0]  cfg_data;
  logic          cfg_ready;
  logic          in_valid;
  logic          in_ready;
  logic [K-1:0]  in_k;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_y;
  logic [15:0]   out_count;

  modport master (
    output cfg_we, cfg_row, cfg_data, in_valid, in_k, out_ready,
    input  cfg_ready, in_ready, out_valid, out_y, out_count
  );

  modport slave (
    input  cfg_we, cfg_row, cfg_data, in_valid, in_k, out_ready,
    output cfg_ready, in_ready, out_valid, out_y, out_count
  );

endinterface

// File: rtl/bmf_pipe_stage.sv
// One valid/ready register slice without skid buffering.
//   up_valid/up_ready/up_data       : upstream side
//   down_valid/down_ready/down_data : downstream side (registered)
// The slice loads whenever it is empty or its contents are being taken.
module bmf_pipe_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         down_valid,
  input  logic         down_ready,
  output logic [W-1:0] down_data
);

  logic         valid_reg;
  logic [W-1:0] data_reg;
  logic         advance;

  assign advance    = !valid_reg || down_ready;
  assign up_ready   = advance;
  assign down_valid = valid_reg;
  assign down_data  = data_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (advance) begin
      valid_reg <= up_valid;
      // Data only changes on a real load so an idle slice keeps its last word.
      if (up_valid) data_reg <= up_data;
    end
  end

endmodule

// File: rtl/bmf_h_decoder.sv
// Streaming BMF decompressor: y = k . H with a runtime-programmable H.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : config port (cfg_*), latent input stream (in_*), and
//                reconstructed output stream (out_*) plus a saturating
//                delivered-vector counter (out_count)
// Pipeline: S1 holds the latent vector, S2 holds the computed product.
module bmf_h_decoder
  import bmf_pkg::*;
#(
  parameter int K        = 3,
  parameter int M        = 4,
  parameter int SEMIRING = SEMIRING_OR
) (
  input  logic clk,
  input  logic rst_n,
  bmf_h_decoder_if.slave bus
);

  localparam int RW = (K > 1) ? $clog2(K) : 1;

  logic [M-1:0]  h_reg [K];
  logic [15:0]   count_reg;
  logic          s1_valid;
  logic [K-1:0]  s1_k;
  logic          s2_ready;
  logic          cfg_ready;
  logic          cfg_accept;
  kvec_t         k_pad;
  hmat_t         h_pad;
  logic [M-1:0]  y_next;

  // Writes are only taken with the whole pipeline idle and no vector
  // arriving, so a vector never sees a half-updated H.
  assign cfg_ready     = !s1_valid && !bus.out_valid && !bus.in_valid;
  assign cfg_accept    = bus.cfg_we && cfg_ready;
  assign bus.cfg_ready = cfg_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) h_reg[i] <= '0;
    end else if (cfg_accept) begin
      // Out-of-range rows match no entry and are silently ignored.
      for (int i = 0; i < K; i++) begin
        if (bus.cfg_row == RW'(i)) h_reg[i] <= bus.cfg_data;
      end
    end
  end

  // Widen H and k to the package maximums for the shared product function.
  assign k_pad = kvec_t'(s1_k);
  generate
    for (genvar gi = 0; gi < K_MAX; gi++) begin : g_hpad
      if (gi < K) begin : g_row
        assign h_pad[gi] = yvec_t'(h_reg[gi]);
      end else begin : g_zero
        assign h_pad[gi] = '0;
      end
    end
  endgenerate

  assign y_next = M'(bmf_product(k_pad, h_pad, SEMIRING));

  bmf_pipe_stage #(.W(K)) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (bus.in_valid),
    .up_ready   (bus.in_ready),
    .up_data    (bus.in_k),
    .down_valid (s1_valid),
    .down_ready (s2_ready),
    .down_data  (s1_k)
  );

  bmf_pipe_stage #(.W(M)) u_s2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (s1_valid),
    .up_ready   (s2_ready),
    .up_data    (y_next),
    .down_valid (bus.out_valid),
    .down_ready (bus.out_ready),
    .down_data  (bus.out_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (bus.out_valid && bus.out_ready && count_reg != 16'hFFFF) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign bus.out_count = count_reg;

endmodule
